// File: rtl/l2_tlb_search_ctrl.sv
// Purpose : search sequencer for one L2 TLB check RAM. Walks every offset of the
//           addressed set through both RAM ports, muxes config writes onto the ports.
// Latency : hit at offset k -> resp_valid_o k+3 cycles after the request handshake;
//           miss -> 2^OFFSET_WIDTH+2 cycles; each cfg write during SEARCH adds one cycle.
// Backpressure: one lookup in flight; req_ready_o only in IDLE, the response is held
//           stable until resp_ready_i; config writes are always accepted and win the ports.
//
// Optional feature macro: RAB_L2_FULL_SET_SEARCH_EN
//   defined   -> no early exit, whole set always searched, first hit reported,
//                resp_multi_o is the OR of multi_hit_i over every valid check cycle
//   undefined -> early exit on the first qualified hit
//
// Ports
//   clk_i, rst_ni                    clock, async active-low reset
//   req_valid_i/req_ready_o          lookup handshake (req_addr_i, req_rw_i)
//   cfg_we_i, cfg_addr_i             config write strobe and RAM address
//   ram_we_o, port0/1_addr_o         RAM write enable and port addresses
//   in_addr_o, rw_type_o             latched request, fed to the check RAM compare
//   output_valid_o, offset_addr_d_o  RAM data of the previous cycle is a search read
//   hit_i, multi_hit_i, prot_i,
//   master_i, hit_addr_i             check RAM results
//   resp_valid_o/resp_ready_i        result handshake, output_sent_o pulses on it
//   resp_*_o                         registered result
module l2_tlb_search_ctrl #(
  parameter int ADDR_WIDTH   = 32,
  parameter int PAGE_SIZE    = 4096,
  parameter int SET_WIDTH    = 5,
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  // lookup request
  input  logic                                req_valid_i,
  output logic                                req_ready_o,
  input  logic [ADDR_WIDTH-1:0]               req_addr_i,
  input  logic                                req_rw_i,
  // configuration writes
  input  logic                                cfg_we_i,
  input  logic [SET_WIDTH+OFFSET_WIDTH:0]     cfg_addr_i,
  // check RAM side
  output logic                                ram_we_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     port0_addr_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     port1_addr_o,
  output logic [ADDR_WIDTH-1:0]               in_addr_o,
  output logic                                rw_type_o,
  output logic                                output_valid_o,
  output logic [OFFSET_WIDTH-1:0]             offset_addr_d_o,
  output logic                                output_sent_o,
  input  logic                                hit_i,
  input  logic                                multi_hit_i,
  input  logic                                prot_i,
  input  logic                                master_i,
  input  logic [SET_WIDTH+OFFSET_WIDTH:0]     hit_addr_i,
  // result
  output logic                                resp_valid_o,
  input  logic                                resp_ready_i,
  output logic                                resp_hit_o,
  output logic                                resp_multi_o,
  output logic                                resp_prot_o,
  output logic                                resp_master_o,
  output logic [SET_WIDTH+OFFSET_WIDTH:0]     resp_hit_addr_o
);

  localparam int IGNORE_LSB = $clog2(PAGE_SIZE);
  localparam int AW         = SET_WIDTH + OFFSET_WIDTH + 1;
  localparam logic [OFFSET_WIDTH-1:0] OFF_LAST = '1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DRAIN  = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic          hit;
    logic          multi;
    logic          prot;
    logic          master;
    logic [AW-1:0] hit_addr;
  } resp_t;

  state_t                  state_q, state_d;
  logic [SET_WIDTH-1:0]    set_q;
  logic [OFFSET_WIDTH-1:0] off_q;
  logic [OFFSET_WIDTH-1:0] off_d_q;
  logic                    issued_q;
  logic [ADDR_WIDTH-1:0]   in_addr_q;
  logic                    rw_q;
  resp_t                   resp_q;

  logic                    issue;
  logic                    latch_req;
  logic                    chk;

  // RAM data is only meaningful while a search is still collecting results;
  // issued_q is already cleared for the read that follows an early exit.
  assign chk = issued_q && ((state_q == SEARCH) || (state_q == DRAIN));

  // --------------------------------------------------------------------------
  // next state / port mux
  // --------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    req_ready_o   = 1'b0;
    resp_valid_o  = 1'b0;
    output_sent_o = 1'b0;
    port0_addr_o  = '0;
    port1_addr_o  = '0;
    issue         = 1'b0;
    latch_req     = 1'b0;

    // config writes own both ports whatever the search is doing
    if (cfg_we_i) begin
      port0_addr_o = cfg_addr_i;
      port1_addr_o = cfg_addr_i;
    end

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          latch_req = 1'b1;
          state_d   = SEARCH;
        end
      end

      SEARCH: begin
        if (!cfg_we_i) begin
          // lower half on port0, upper half on port1, same offset
          port0_addr_o = {1'b0, set_q, off_q};
          port1_addr_o = {1'b1, set_q, off_q};
          issue        = 1'b1;
          if (off_q == OFF_LAST) begin
            state_d = DRAIN;
          end
        end
`ifndef RAB_L2_FULL_SET_SEARCH_EN
        // a qualified hit overrides the move to DRAIN issued in the same cycle
        if (chk && hit_i) begin
          state_d = RESP;
        end
`endif
      end

      DRAIN: begin
        // the last read is checked here whether or not a cfg write is on the ports
        if (chk) begin
          state_d = RESP;
        end
      end

      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_ready_i) begin
          output_sent_o = 1'b1;
          state_d       = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      set_q     <= '0;
      off_q     <= '0;
      off_d_q   <= '0;
      issued_q  <= 1'b0;
      in_addr_q <= '0;
      rw_q      <= 1'b0;
    end else begin
      state_q <= state_d;

      if (latch_req) begin
        in_addr_q <= req_addr_i;
        rw_q      <= req_rw_i;
        set_q     <= req_addr_i[IGNORE_LSB +: SET_WIDTH];
        off_q     <= '0;
      end else if (issue && (off_q != OFF_LAST)) begin
        // holding at the last offset keeps off_q from wrapping
        off_q <= off_q + 1'b1;
      end

      // leaving for RESP discards the speculative read issued alongside the hit
      issued_q <= issue && (state_d != RESP);

      if (issue) begin
        off_d_q <= off_q;
      end
    end
  end

  // --------------------------------------------------------------------------
  // result registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else begin
`ifdef RAB_L2_FULL_SET_SEARCH_EN
      if (latch_req) begin
        resp_q <= '0;
      end else if (chk) begin
        // keep the first hit; later hits only contribute to the multi-hit flag
        if (hit_i && !resp_q.hit) begin
          resp_q.hit      <= 1'b1;
          resp_q.prot     <= prot_i;
          resp_q.master   <= master_i;
          resp_q.hit_addr <= hit_addr_i;
        end
        resp_q.multi <= resp_q.multi | multi_hit_i;
      end
`else
      // the only ways into RESP are a qualified hit or the final DRAIN check
      if (chk && (state_d == RESP)) begin
        if (hit_i) begin
          resp_q <= {1'b1, multi_hit_i, prot_i, master_i, hit_addr_i};
        end else begin
          resp_q <= '0;
        end
      end
`endif
    end
  end

  // --------------------------------------------------------------------------
  // outputs
  // --------------------------------------------------------------------------
  assign ram_we_o        = cfg_we_i;
  assign in_addr_o       = in_addr_q;
  assign rw_type_o       = rw_q;
  assign output_valid_o  = issued_q;
  assign offset_addr_d_o = off_d_q;

  assign resp_hit_o      = resp_q.hit;
  assign resp_multi_o    = resp_q.multi;
  assign resp_prot_o     = resp_q.prot;
  assign resp_master_o   = resp_q.master;
  assign resp_hit_addr_o = resp_q.hit_addr;

endmodule
